scan_link_receiver: RTL
=======================

SCAN_LINK_RECEIVER -- requirements
Module: scan_link_receiver

Interface
REQ-001 Parameter TIMEOUT, default 16: clk cycles with linkClk low that abort a partial frame.
REQ-002 clk  input  1  system clock; all logic on posedge clk.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 linkClk  input  1  bit strobe from the scanner serial output; each clk cycle it is high carries one bit.
REQ-005 linkData  input  1  serial data bit, valid when linkClk=1.
REQ-006 rxEnable  input  1  receiver willing to accept a data transfer.
REQ-007 readyForTransfer  output  1  high when rxEnable=1 and state is IDLE; drives the scanner readyForTransferIn.
REQ-008 cmdValid  output  1  one-cycle pulse per decoded legal command byte.
REQ-009 cmdCode  output  8  last legal command byte; held until the next legal command.
REQ-010 dataValid  output  1  one-cycle pulse per received payload byte.
REQ-011 dataByte  output  8  last payload byte; held until the next payload byte.
REQ-012 dataCount  output  8  number of payload bytes received, wraps 255->0.
REQ-013 cmdError  output  1  one-cycle pulse on an illegal command byte.
REQ-014 timeoutError  output  1  one-cycle pulse when a partial frame is aborted.

Function
REQ-015 Each clk cycle with linkClk=1 SHALL write linkData into shift bit [bitCount] (LSB first) and increment the 3-bit bitCount, wrapping 7->0.
REQ-016 A strobe with bitCount=7 completes a byte; the decode result SHALL appear on the outputs the next clk cycle (1-cycle latency).
REQ-017 States: IDLE=2'b00 (expect command), DATA=2'b01 (expect payload); encodings 2'b10 and 2'b11 SHALL return to IDLE.
REQ-018 In IDLE, a complete byte of 2 (READY_TO_TRANSFER), 3 (START_SCANNING) or 4 (BUFFER_FULL) SHALL pulse cmdValid, load cmdCode, and stay in IDLE.
REQ-019 In IDLE, a complete byte of 7 (DATA_TRANSFER) SHALL pulse cmdValid, load cmdCode=7, and go to DATA.
REQ-020 In IDLE, any other byte value SHALL pulse cmdError and leave cmdCode, state and dataCount unchanged.
REQ-021 In DATA, the next complete byte SHALL be taken as payload, whatever its value: pulse dataValid, load dataByte, increment dataCount, and return to IDLE.
REQ-022 Idle counter: counts clk cycles with linkClk=0 while bitCount!=0 or state=DATA; clears on any strobe.
REQ-023 When the idle counter reaches TIMEOUT: clear bitCount, go to IDLE, pulse timeoutError, and discard the partial byte (no cmdValid, dataValid or cmdError).
REQ-024 In IDLE with bitCount=0, the idle counter SHALL hold at 0 and never time out.
REQ-025 Back-to-back frames with no gap cycle SHALL decode correctly: a strobe in the cycle after byte completion is bit 0 of the next byte.
REQ-026 readyForTransfer SHALL fall in the cycle after entry to DATA and SHALL rise in the cycle after return to IDLE, when rxEnable=1.
REQ-027 The pulse outputs cmdValid, dataValid, cmdError and timeoutError SHALL be mutually exclusive in any cycle.

Reset
REQ-028 rst=1 SHALL set state IDLE, bitCount 0, idle counter 0, shift register 0, cmdCode 0, dataByte 0, dataCount 0, and all pulse outputs 0.
REQ-029 While rst=1, readyForTransfer SHALL be 0.
REQ-030 rst asserted mid-frame SHALL discard the partial byte and SHALL NOT pulse timeoutError.
REQ-031 rst SHALL take priority over a strobe in the same cycle.

Structure
REQ-032 A shared package SHALL hold the state encodings IDLE/DATA and the command constants 8'd2, 8'd3, 8'd4, 8'd7; the scanner transmitter SHALL use the same package.
REQ-033 One sub-module, link_deserializer, SHALL contain the shift register, bitCount and idle counter, and output byteDone, byteOut and timeout; the FSM and decode logic SHALL sit in the top module.

Verification
REQ-034 Send 8 strobed bits of 0x02 LSB first -> one cycle later cmdValid=1 and cmdCode=0x02; state stays IDLE; readyForTransfer=1 with rxEnable=1.
REQ-035 Send 0x07 then 0x05 back-to-back -> cmdValid with cmdCode=7, readyForTransfer drops, then dataValid with dataByte=0x05, dataCount=1, readyForTransfer rises.
REQ-036 Send 0x09 in IDLE -> cmdError pulse; cmdCode keeps its prior value; no cmdValid.
REQ-037 Send 5 bits, then hold linkClk low for 16 cycles -> timeoutError pulse in the cycle the idle counter reaches 16; a following 0x03 decodes as cmdValid with cmdCode=3.
REQ-038 Send 0x07, then assert rst after 4 payload bits -> all outputs at reset values; no timeoutError; the next 0x04 decodes as a command.
REQ-039 Send 256 pairs of 0x07 plus payload -> dataCount wraps to 0 on the 256th dataValid.

Source files
------------

// File: rtl/scan_link_receiver_pkg.sv
// Shared definitions for the scanner serial link: receiver states and command bytes.
// The scanner transmitter imports the same package so both ends agree on the encodings.
package scan_link_receiver_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    DATA = 2'b01
  } rx_state_t;

  localparam logic [7:0] CMD_READY_TO_TRANSFER = 8'd2;
  localparam logic [7:0] CMD_START_SCANNING    = 8'd3;
  localparam logic [7:0] CMD_BUFFER_FULL       = 8'd4;
  localparam logic [7:0] CMD_DATA_TRANSFER     = 8'd7;

  // Commands that are acknowledged without opening a payload slot.
  function automatic logic is_plain_cmd(input logic [7:0] b);
    return (b == CMD_READY_TO_TRANSFER) || (b == CMD_START_SCANNING) ||
           (b == CMD_BUFFER_FULL);
  endfunction

endpackage

// File: rtl/scan_link_receiver_if.sv
// Scanner-to-receiver link bundle: serial strobe/data in, flow control and decoded results out.
interface scan_link_receiver_if;
  logic       linkClk;
  logic       linkData;
  logic       rxEnable;
  logic       readyForTransfer;
  logic       cmdValid;
  logic [7:0] cmdCode;
  logic       dataValid;
  logic [7:0] dataByte;
  logic [7:0] dataCount;
  logic       cmdError;
  logic       timeoutError;

  modport master (
    output linkClk, linkData, rxEnable,
    input  readyForTransfer, cmdValid, cmdCode, dataValid, dataByte, dataCount,
           cmdError, timeoutError
  );

  modport slave (
    input  linkClk, linkData, rxEnable,
    output readyForTransfer, cmdValid, cmdCode, dataValid, dataByte, dataCount,
           cmdError, timeoutError
  );
endinterface

// File: rtl/scan_link_receiver_link_deserializer.sv
// Bit assembler for the scanner link: LSB-first shift register, bit counter and stall timer.
// byteDone/byteOut/timeout are combinational so the FSM can register its result on the same edge.
module link_deserializer #(
  parameter int TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       linkClk,
  input  logic       linkData,
  input  logic       inData,
  output logic       byteDone,
  output logic [7:0] byteOut,
  output logic       timeout
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [7:0]    shift;
  logic [2:0]    bitCount;
  logic [CW-1:0] idleCount;
  logic          counting;

  // A frame is in flight if bits are pending or a payload byte is owed.
  assign counting = (bitCount != 3'd0) || inData;
  assign byteDone = linkClk && (bitCount == 3'd7);
  assign timeout  = !linkClk && counting && (idleCount == CW'(TIMEOUT - 1));

  always_comb begin
    byteOut           = shift;
    byteOut[bitCount] = linkData;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shift     <= '0;
      bitCount  <= '0;
      idleCount <= '0;
    end else if (linkClk) begin
      shift[bitCount] <= linkData;
      bitCount        <= bitCount + 3'd1;
      idleCount       <= '0;
    end else if (timeout) begin
      shift     <= '0;
      bitCount  <= '0;
      idleCount <= '0;
    end else if (counting) begin
      idleCount <= idleCount + CW'(1);
    end else begin
      idleCount <= '0;
    end
  end

endmodule

// File: rtl/scan_link_receiver.sv
// Scanner link receiver: decodes command bytes, captures the payload byte after DATA_TRANSFER,
// and aborts stalled frames.
//   state | meaning
//   IDLE  | expecting a command byte; ready for transfer when enabled
//   DATA  | expecting exactly one payload byte
module scan_link_receiver
  import scan_link_receiver_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input logic              clk,
  input logic              rst,
  scan_link_receiver_if.slave bus
);

  rx_state_t  state;
  logic       byteDone;
  logic [7:0] byteOut;
  logic       timeout;

  logic       cmdValid;
  logic [7:0] cmdCode;
  logic       dataValid;
  logic [7:0] dataByte;
  logic [7:0] dataCount;
  logic       cmdError;
  logic       timeoutError;

  link_deserializer #(.TIMEOUT(TIMEOUT)) u_deser (
    .clk      (clk),
    .rst      (rst),
    .linkClk  (bus.linkClk),
    .linkData (bus.linkData),
    .inData   (state == DATA),
    .byteDone (byteDone),
    .byteOut  (byteOut),
    .timeout  (timeout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cmdValid     <= 1'b0;
      cmdCode      <= '0;
      dataValid    <= 1'b0;
      dataByte     <= '0;
      dataCount    <= '0;
      cmdError     <= 1'b0;
      timeoutError <= 1'b0;
    end else begin
      cmdValid     <= 1'b0;
      dataValid    <= 1'b0;
      cmdError     <= 1'b0;
      timeoutError <= 1'b0;
      case (state)
        IDLE: begin
          if (timeout) begin
            timeoutError <= 1'b1;
          end else if (byteDone) begin
            if (is_plain_cmd(byteOut)) begin
              cmdValid <= 1'b1;
              cmdCode  <= byteOut;
            end else if (byteOut == CMD_DATA_TRANSFER) begin
              cmdValid <= 1'b1;
              cmdCode  <= byteOut;
              state    <= DATA;
            end else begin
              cmdError <= 1'b1;
            end
          end
        end
        DATA: begin
          if (timeout) begin
            timeoutError <= 1'b1;
            state        <= IDLE;
          end else if (byteDone) begin
            dataValid <= 1'b1;
            dataByte  <= byteOut;
            dataCount <= dataCount + 8'd1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.readyForTransfer = bus.rxEnable && (state == IDLE) && !rst;
  assign bus.cmdValid         = cmdValid;
  assign bus.cmdCode          = cmdCode;
  assign bus.dataValid        = dataValid;
  assign bus.dataByte         = dataByte;
  assign bus.dataCount        = dataCount;
  assign bus.cmdError         = cmdError;
  assign bus.timeoutError     = timeoutError;

endmodule
